// File: rtl/pio_bank.sv
// pio_bank: NCH channels of W-bit synchronised inputs and writable outputs behind one Avalon-MM slave.
// Define PIO_BANK_IRQ_EN to add per-bit rising-edge capture (EDGE), an irq mask (MASK) and the irq output.
module pio_bank #(
    parameter int NCH = 8,
    parameter int W   = 8,
    parameter int AW  = 2 + $clog2(NCH)
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [AW-1:0]     avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [W-1:0]      avs_writedata,
    output logic [W-1:0]      avs_readdata,
    input  logic [NCH*W-1:0]  in_export,
    output logic [NCH*W-1:0]  out_export,
    output logic              irq
);
    localparam logic [1:0] F_DATA  = 2'd0;
    localparam logic [1:0] F_OUTRB = 2'd1;
    localparam int         CHW     = (AW > 2) ? AW - 2 : 1;

    logic [1:0]            func;
    logic [CHW-1:0]        ch;
    logic [2**CHW-1:0]     ch_ok;
    logic                  wr_ok;

    logic [NCH-1:0][W-1:0] sync1_q;
    logic [NCH-1:0][W-1:0] sync2_q;
    logic [NCH-1:0][W-1:0] out_q;
    logic [NCH-1:0][W-1:0] out_d;
    logic [W-1:0]          readdata_q;
    logic [W-1:0]          readdata_d;

    assign func = avs_address[AW-1:AW-2];

    // A single-channel bank has no channel field in the address.
    if (AW > 2) begin : g_ch
        assign ch = avs_address[AW-3:0];
    end else begin : g_ch0
        assign ch = '0;
    end

    for (genvar i = 0; i < 2**CHW; i++) begin : g_ok
        assign ch_ok[i] = (i < NCH);
    end

    assign wr_ok        = avs_write & ch_ok[ch];
    assign out_export   = out_q;
    assign avs_readdata = readdata_q;

    always_comb begin
        out_d = out_q;
        if (wr_ok && func == F_DATA) begin
            out_d[ch] = avs_writedata;
        end
    end

`ifdef PIO_BANK_IRQ_EN
    localparam logic [1:0] F_EDGE = 2'd2;
    localparam logic [1:0] F_MASK = 2'd3;

    logic [NCH-1:0][W-1:0] prev_q;
    logic [NCH-1:0][W-1:0] edge_q;
    logic [NCH-1:0][W-1:0] edge_d;
    logic [NCH-1:0][W-1:0] mask_q;
    logic [NCH-1:0][W-1:0] mask_d;
    logic [NCH-1:0][W-1:0] clr;

    // A rise in the same cycle as a write-1-to-clear keeps the bit set.
    always_comb begin
        clr    = '0;
        mask_d = mask_q;
        if (wr_ok && func == F_EDGE) begin
            clr[ch] = avs_writedata;
        end
        if (wr_ok && func == F_MASK) begin
            mask_d[ch] = avs_writedata;
        end
        edge_d = (edge_q & ~clr) | (sync2_q & ~prev_q);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            prev_q <= '0;
            edge_q <= '0;
            mask_q <= '0;
        end else begin
            prev_q <= sync2_q;
            edge_q <= edge_d;
            mask_q <= mask_d;
        end
    end

    assign irq = |(edge_q & mask_q);
`else
    assign irq = 1'b0;
`endif

    // Read mux sees pre-edge register values, so a same-cycle write is not visible.
    always_comb begin
        readdata_d = '0;
        if (ch_ok[ch]) begin
            case (func)
                F_DATA:  readdata_d = sync2_q[ch];
                F_OUTRB: readdata_d = out_q[ch];
`ifdef PIO_BANK_IRQ_EN
                F_EDGE:  readdata_d = edge_q[ch];
                F_MASK:  readdata_d = mask_q[ch];
`endif
                default: readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            out_q      <= '0;
            readdata_q <= '0;
        end else begin
            sync1_q <= in_export;
            sync2_q <= sync1_q;
            out_q   <= out_d;
            if (avs_read) begin
                readdata_q <= readdata_d;
            end
        end
    end

endmodule
